csd2bin_serial: RTL and testbench

- Digit-serial canonical-signed-digit (CSD) to two's-complement binary converter. It is the inverse of the combinational bin2csd block.
- Consumes one CSD digit per accepted cycle, MSB first, over a valid/ready stream, and presents the W-digit word as a (W+1)-bit signed result on a valid/ready output.
- Sits at the boundary between the digit-serial BKM datapath and the binary result registers of the FPU.

---
 rtl/csd2bin_serial_pkg.sv | 15 +
 rtl/csd2bin_serial_digit_decode.sv | 22 ++
 rtl/csd2bin_serial.sv | 122 ++++++++++++
 tb/tb_csd2bin_serial.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/csd2bin_serial_pkg.sv
// Shared CSD digit codes and FSM encodings for the digit-serial CSD converters.
package csd2bin_serial_pkg;

  localparam logic [1:0] CSD_0   = 2'b00;
  localparam logic [1:0] CSD_P1  = 2'b01;
  localparam logic [1:0] CSD_M1  = 2'b10;
  localparam logic [1:0] CSD_ILL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/csd2bin_serial_digit_decode.sv
// csd_digit_decode: maps a 2-bit CSD code to a signed digit value plus an illegal flag.
module csd_digit_decode
  import csd2bin_serial_pkg::*;
(
  input  logic [1:0]        code_i,
  output logic signed [1:0] val_o,
  output logic              ill_o
);

  always_comb begin
    val_o = 2'sb00;
    ill_o = 1'b0;
    case (code_i)
      CSD_0:   val_o = 2'sb00;
      CSD_P1:  val_o = 2'sb01;
      CSD_M1:  val_o = 2'sb11;
      CSD_ILL: ill_o = 1'b1;  // illegal code contributes 0 to the value
      default: ill_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/csd2bin_serial.sv
// Digit-serial CSD (MSB first) to two's-complement converter with valid/ready on both sides.
// Optional non-adjacency checking is enabled by defining CSD2BIN_NAF_CHECK_EN.
module csd2bin_serial
  import csd2bin_serial_pkg::*;
#(
  parameter int W        = 5,
  parameter int CNT_SIZE = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W:0]   out_y,
  output logic         out_err
);

  localparam logic [CNT_SIZE-1:0] LAST_CNT = CNT_SIZE'(W - 1);

  state_e                state_q;
  logic signed [W:0]     acc_q;
  logic [CNT_SIZE-1:0]   cnt_q;
  logic                  err_q;
  logic                  out_valid_q;
  logic                  in_ready_q;

  logic signed [1:0]     dig_val;
  logic                  dig_ill;
  logic signed [W:0]     dig_ext;
  logic signed [W:0]     acc_d;
  logic                  err_d;
  logic                  naf_viol;
  logic                  accept;

  csd_digit_decode u_decode (
    .code_i (in_digit),
    .val_o  (dig_val),
    .ill_o  (dig_ill)
  );

  assign accept  = in_valid && in_ready_q;
  assign dig_ext = {{(W-1){dig_val[1]}}, dig_val};
  assign acc_d   = (acc_q <<< 1) + dig_ext;
  assign err_d   = err_q | dig_ill | naf_viol;

`ifdef CSD2BIN_NAF_CHECK_EN
  logic nz_prev_q;
  logic dig_nz;

  assign dig_nz   = (dig_val != 2'sb00);
  assign naf_viol = nz_prev_q && dig_nz;

  // Remembers whether the last accepted digit of this word was nonzero.
  always_ff @(posedge clk) begin
    if (rst || state_q == ST_DONE) begin
      nz_prev_q <= 1'b0;
    end else if (accept) begin
      nz_prev_q <= dig_nz;
    end
  end
`else
  assign naf_viol = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc_q   <= dig_ext;
            err_q   <= dig_ill;
            cnt_q   <= CNT_SIZE'(1);
            state_q <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            err_q <= err_d;
            cnt_q <= cnt_q + CNT_SIZE'(1);
            if (cnt_q == LAST_CNT) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
            end
          end
        end
        ST_DONE: begin
          // Input stays blocked during the handshake cycle, so words are W+1 cycles apart at best.
          if (out_ready) begin
            acc_q       <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = acc_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_csd2bin_serial.sv
// Randomised self-checking bench for csd2bin_serial against an arithmetic word model.
module tb_csd2bin_serial;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_digit = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W:0]   out_y;
  logic         out_err;

  int total = 0;
  int bad   = 0;

  csd2bin_serial #(.W(W), .CNT_SIZE(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Reference: value = sum of digit * 2^position, MSB first; err from illegal codes (and adjacency when enabled).
  function automatic void model(input logic [2*W-1:0] codes, output int val, output bit err);
    bit prev_nz = 1'b0;
    val = 0;
    err = 1'b0;
    for (int i = 0; i < W; i++) begin
      logic [1:0] c;
      int d;
      c = codes[2*(W-1-i) +: 2];
      d = (c == 2'b01) ? 1 : (c == 2'b10) ? -1 : 0;
      if (c == 2'b11) err = 1'b1;
`ifdef CSD2BIN_NAF_CHECK_EN
      if (prev_nz && d != 0) err = 1'b1;
`endif
      prev_nz = (d != 0);
      val = val + d * (1 << (W-1-i));
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the digit was accepted.
  task automatic send_digit(input logic [1:0] code, input bit gaps);
    int guard = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_digit = 2'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_digit = code;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL in_ready_wait: actual=%0b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_digit = 2'($urandom);
  endtask

  task automatic run_word(input string name, input logic [2*W-1:0] codes, input bit gaps, input int hold);
    int        val;
    bit        err;
    logic [W:0] exp_y;
    model(codes, val, err);
    exp_y = (W+1)'(val);
    out_ready = (hold == 0);
    for (int i = 0; i < W; i++) begin
      send_digit(codes[2*(W-1-i) +: 2], gaps);
      if (i < W-1) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s early_valid: actual=%0b required=0 digit=%0d", name, out_valid, i);
        end
      end
    end
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s latency: actual valid=%0b ready=%0b required valid=1 ready=0", name, out_valid, in_ready);
    end
    total++;
    if (out_y !== exp_y || out_err !== err) begin
      bad++;
      $display("FAIL %s value: actual y=%0d err=%0b required y=%0d err=%0b",
               name, $signed(out_y), out_err, $signed(exp_y), err);
    end
    $display("word %s: y=%0d err=%0b", name, $signed(out_y), out_err);
    repeat (hold) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== exp_y || out_err !== err) begin
        bad++;
        $display("FAIL %s hold: actual valid=%0b ready=%0b y=%0d err=%0b required 1 0 %0d %0b",
                 name, out_valid, in_ready, $signed(out_y), out_err, $signed(exp_y), err);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s release: actual valid=%0b ready=%0b required valid=0 ready=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || out_y !== '0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: actual valid=%0b y=%0d err=%0b ready=%0b required 0 0 0 1",
               out_valid, out_y, out_err, in_ready);
    end
  endtask

  task automatic test_directed();
    run_word("p0m0p",   {2'b01, 2'b00, 2'b10, 2'b00, 2'b01}, 1'b0, 0);
    run_word("m0m0m",   {2'b10, 2'b00, 2'b10, 2'b00, 2'b10}, 1'b0, 0);
    run_word("hold3",   {2'b10, 2'b00, 2'b10, 2'b00, 2'b10}, 1'b0, 3);
    run_word("illegal", {2'b00, 2'b11, 2'b01, 2'b00, 2'b00}, 1'b0, 0);
    run_word("clean",   {2'b00, 2'b01, 2'b00, 2'b00, 2'b10}, 1'b0, 0);
    run_word("adjacent",{2'b01, 2'b01, 2'b00, 2'b00, 2'b00}, 1'b0, 0);
  endtask

  task automatic test_round_trip();
    for (int x = 0; x < 32; x++) begin
      logic [2*W-1:0] codes;
      int k = x;
      int pos = 0;
      bit fits = 1'b1;
      codes = '0;
      // Non-adjacent form, LSB first; fall back to plain binary digits when it needs W+1 digits.
      while (k != 0) begin
        int d = 0;
        if (k % 2 != 0) d = 2 - (k % 4);
        k = (k - d) / 2;
        if (pos >= W) fits = 1'b0;
        else codes[2*pos +: 2] = (d == 1) ? 2'b01 : (d == -1) ? 2'b10 : 2'b00;
        pos++;
      end
      if (!fits) begin
        for (int b = 0; b < W; b++) codes[2*b +: 2] = ((x >> b) & 1) != 0 ? 2'b01 : 2'b00;
      end
      run_word($sformatf("rt%0d", x), codes, 1'b1, 0);
      total++;
      if (fits && (out_err !== 1'b0 || dut.acc_q !== '0)) begin
        // after release the result register is cleared and no error is pending
        bad++;
        $display("FAIL rt%0d cleared: actual err=%0b required 0", x, out_err);
      end
    end
  endtask

  task automatic test_reset_mid_word();
    send_digit(2'b01, 1'b0);
    send_digit(2'b11, 1'b0);
    send_digit(2'b10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_err !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid: actual valid=%0b ready=%0b err=%0b required 0 1 0", out_valid, in_ready, out_err);
      end
    end
    run_word("after_rst", {2'b01, 2'b00, 2'b00, 2'b10, 2'b00}, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [2*W-1:0] codes;
      codes = (2*W)'($urandom);
      run_word($sformatf("rnd%0d", n), codes, 1'b1, int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round_trip();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
